// File: rtl/axi_mm_resp_pkg.sv
// Shared types and AXI encodings for the memory-mapped AXI4 responder.
package axi_mm_resp_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

endpackage

// File: rtl/axi_mm_resp_ram.sv
// Simple dual-port word array with per-byte write enables and a registered read port.
// A read and write to the same word in one cycle returns the previous contents.
module axi_mm_resp_ram #(
  parameter int DATA_WIDTH = 512,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [DEPTH_LOG2-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    rd_en,
  input  logic [DEPTH_LOG2-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int DATA_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  // One narrow array per byte lane keeps each lane a plain write-enabled RAM.
  generate
    for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
      logic [7:0] lane_mem [0:DEPTH-1];
      logic [7:0] lane_rd_reg;

      always_ff @(posedge clk) begin
        if (wr_en && wr_strb[gi]) begin
          lane_mem[wr_addr] <= wr_data[gi*8 +: 8];
        end
        if (rd_en) begin
          lane_rd_reg <= lane_mem[rd_addr];
        end
      end

      assign rd_data[gi*8 +: 8] = lane_rd_reg;
    end
  endgenerate

endmodule

// File: rtl/axi_mm_mem_responder.sv
// AXI4 subordinate backed by a local word array; independent single-outstanding
// write and read burst engines with burst counters and a sticky WLAST error flag.
module axi_mm_mem_responder
  import axi_mm_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 9,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [1:0]              awburst,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [1:0]              arburst,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic [31:0]             wr_burst_cnt,
  output logic [31:0]             rd_burst_cnt,
  output logic                    err_wlast
);

  localparam int DATA_BYTES = DATA_WIDTH / 8;
  localparam int BYTE_OFF   = $clog2(DATA_BYTES);

  wr_state_t             wr_state_reg, wr_state_next;
  logic [ID_WIDTH-1:0]   aw_id_reg;
  logic [DEPTH_LOG2-1:0] wr_index_reg;
  logic [7:0]            aw_len_reg;
  logic [7:0]            wr_beat_reg;
  logic                  wr_discard_reg;
  logic                  wr_err_reg;
  logic                  err_wlast_reg;
  logic [31:0]           wr_burst_cnt_reg;
  logic                  wr_last_beat;
  logic                  ram_wr_en;

  rd_state_t             rd_state_reg, rd_state_next;
  logic [ID_WIDTH-1:0]   ar_id_reg;
  logic [DEPTH_LOG2-1:0] rd_index_reg;
  logic [7:0]            ar_len_reg;
  logic [7:0]            rd_beat_reg;
  logic                  rd_err_reg;
  logic [31:0]           rd_burst_cnt_reg;
  logic                  rd_last_beat;
  logic                  ram_rd_en;
  logic [DEPTH_LOG2-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  // Address bits outside the word index are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr, araddr};

  assign wr_last_beat = (wr_beat_reg == aw_len_reg);
  assign rd_last_beat = (rd_beat_reg == ar_len_reg);

  // ---------------- write engine ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_reg <= W_IDLE;
    end else begin
      wr_state_reg <= wr_state_next;
    end
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    awready       = 1'b0;
    wready        = 1'b0;
    bvalid        = 1'b0;
    case (wr_state_reg)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) wr_state_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && wr_last_beat) wr_state_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) wr_state_next = W_IDLE;
      end
      default: wr_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_id_reg        <= '0;
      wr_index_reg     <= '0;
      aw_len_reg       <= '0;
      wr_beat_reg      <= '0;
      wr_discard_reg   <= 1'b0;
      wr_err_reg       <= 1'b0;
      err_wlast_reg    <= 1'b0;
      wr_burst_cnt_reg <= '0;
    end else begin
      case (wr_state_reg)
        W_IDLE: begin
          if (awvalid) begin
            aw_id_reg      <= awid;
            wr_index_reg   <= awaddr[BYTE_OFF +: DEPTH_LOG2];
            aw_len_reg     <= awlen;
            wr_beat_reg    <= '0;
            wr_discard_reg <= (awburst != AXI_BURST_INCR);
            wr_err_reg     <= (awburst != AXI_BURST_INCR);
          end
        end
        W_DATA: begin
          if (wvalid) begin
            wr_beat_reg  <= wr_beat_reg + 8'd1;
            wr_index_reg <= wr_index_reg + DEPTH_LOG2'(1);
            // Beat count terminates the burst; a misplaced WLAST only flags it.
            if (wlast != wr_last_beat) begin
              wr_err_reg    <= 1'b1;
              err_wlast_reg <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (bready) wr_burst_cnt_reg <= wr_burst_cnt_reg + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign ram_wr_en    = (wr_state_reg == W_DATA) && wvalid && !wr_discard_reg;
  assign bid          = aw_id_reg;
  assign bresp        = (bvalid && wr_err_reg) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign err_wlast    = err_wlast_reg;
  assign wr_burst_cnt = wr_burst_cnt_reg;

  // ---------------- read engine ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_reg <= R_IDLE;
    end else begin
      rd_state_reg <= rd_state_next;
    end
  end

  // R_ADDR fetches the first word; each accepted beat prefetches the next one,
  // so the RAM output register doubles as the stall-stable rdata holder.
  always_comb begin
    rd_state_next = rd_state_reg;
    arready       = 1'b0;
    rvalid        = 1'b0;
    ram_rd_en     = 1'b0;
    ram_rd_addr   = rd_index_reg;
    case (rd_state_reg)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) rd_state_next = R_ADDR;
      end
      R_ADDR: begin
        ram_rd_en     = 1'b1;
        rd_state_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready) begin
          if (rd_last_beat) begin
            rd_state_next = R_IDLE;
          end else begin
            ram_rd_en   = 1'b1;
            ram_rd_addr = rd_index_reg + DEPTH_LOG2'(1);
          end
        end
      end
      default: rd_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_id_reg        <= '0;
      rd_index_reg     <= '0;
      ar_len_reg       <= '0;
      rd_beat_reg      <= '0;
      rd_err_reg       <= 1'b0;
      rd_burst_cnt_reg <= '0;
    end else begin
      case (rd_state_reg)
        R_IDLE: begin
          if (arvalid) begin
            ar_id_reg    <= arid;
            rd_index_reg <= araddr[BYTE_OFF +: DEPTH_LOG2];
            ar_len_reg   <= arlen;
            rd_beat_reg  <= '0;
            rd_err_reg   <= (arburst != AXI_BURST_INCR);
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rd_last_beat) begin
              rd_burst_cnt_reg <= rd_burst_cnt_reg + 32'd1;
            end else begin
              rd_beat_reg  <= rd_beat_reg + 8'd1;
              rd_index_reg <= rd_index_reg + DEPTH_LOG2'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rid          = ar_id_reg;
  assign rdata        = (rvalid && !rd_err_reg) ? ram_rd_data : '0;
  assign rresp        = (rvalid && rd_err_reg) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign rlast        = rvalid && rd_last_beat;
  assign rd_burst_cnt = rd_burst_cnt_reg;

  axi_mm_resp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (wr_index_reg),
    .wr_data (wdata),
    .wr_strb (wstrb),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

endmodule

// File: tb/tb_axi_mm_mem_responder.sv
// Directed + randomized bench for axi_mm_mem_responder against a word-array
// reference model; all DUT sampling and driving happens on the falling edge.
module tb_axi_mm_mem_responder;

  localparam int          AW   = 32;
  localparam int          DW   = 512;
  localparam int          DB   = DW / 8;
  localparam int          IW   = 9;
  localparam int          NW   = 1024;
  localparam logic [1:0]  INCR = 2'b01;
  localparam logic [1:0]  FIXD = 2'b00;

  logic          clk = 1'b0;
  logic          rst;
  logic          awvalid, awready;
  logic [IW-1:0] awid;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [1:0]    awburst;
  logic          wvalid, wready;
  logic [DW-1:0] wdata;
  logic [DB-1:0] wstrb;
  logic          wlast;
  logic          bvalid, bready;
  logic [IW-1:0] bid;
  logic [1:0]    bresp;
  logic          arvalid, arready;
  logic [IW-1:0] arid;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [1:0]    arburst;
  logic          rvalid, rready;
  logic [IW-1:0] rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic [31:0]   wr_burst_cnt, rd_burst_cnt;
  logic          err_wlast;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int exp_wr_cnt = 0;
  int exp_rd_cnt = 0;

  logic [DW-1:0] model_mem  [0:NW-1];
  logic [DW-1:0] wbeat_data [0:255];
  logic [DB-1:0] wbeat_strb [0:255];

  always #5 clk = ~clk;

  axi_mm_mem_responder dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast),
    .wr_burst_cnt(wr_burst_cnt), .rd_burst_cnt(rd_burst_cnt), .err_wlast(err_wlast)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic int word_of(input logic [AW-1:0] a);
    return int'(a / DB) % NW;
  endfunction

  // Drives a full write burst from wbeat_data/wbeat_strb; bad_beat>=0 flips WLAST on that beat.
  task automatic write_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                             input int len, input logic [1:0] burst, input int bad_beat);
    int  cyc;
    int  idx;
    logic exp_err;
    exp_err = (burst != INCR);
    @(negedge clk);
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = 8'(len); awburst = burst;
    cyc = 0;
    while (!awready && cyc < 100) begin @(negedge clk); cyc++; end
    check("awready", DW'(awready), DW'(1));
    @(negedge clk);
    awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      wvalid = 1'b1; wdata = wbeat_data[b]; wstrb = wbeat_strb[b];
      wlast  = (b == len) ^ (b == bad_beat);
      if (b == bad_beat) exp_err = 1'b1;
      cyc = 0;
      while (!wready && cyc < 100) begin @(negedge clk); cyc++; end
      check($sformatf("wready[%0d]", b), DW'(wready), DW'(1));
      @(negedge clk);
      if (burst == INCR) begin
        idx = (word_of(addr) + b) % NW;
        for (int k = 0; k < DB; k++)
          if (wbeat_strb[b][k]) model_mem[idx][k*8 +: 8] = wbeat_data[b][k*8 +: 8];
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("wready_after_last", DW'(wready), DW'(0));
    repeat ($urandom_range(0, 2)) @(negedge clk);
    check("bvalid", DW'(bvalid), DW'(1));
    check("bresp", DW'(bresp), exp_err ? DW'(2) : DW'(0));
    check("bid", DW'(bid), DW'(id));
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    exp_wr_cnt++;
    check("bvalid_after", DW'(bvalid), DW'(0));
    check("wr_burst_cnt", DW'(wr_burst_cnt), DW'(exp_wr_cnt));
    $display("WR id=%0h addr=%08h len=%0d burst=%0d bresp=%0d", id, addr, len, burst, bresp);
  endtask

  // mode 0: rready always 1; 1: toggles 1/0; 2: random.
  task automatic read_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                            input int len, input logic [1:0] burst, input int mode);
    int cyc;
    int beat;
    logic rr;
    logic [DW-1:0] exp_d;
    @(negedge clk);
    arvalid = 1'b1; arid = id; araddr = addr; arlen = 8'(len); arburst = burst;
    cyc = 0;
    while (!arready && cyc < 100) begin @(negedge clk); cyc++; end
    check("arready", DW'(arready), DW'(1));
    @(negedge clk);
    arvalid = 1'b0;
    check("rvalid_ar_plus1", DW'(rvalid), DW'(0));
    @(negedge clk);
    check("rvalid_ar_plus2", DW'(rvalid), DW'(1));
    beat = 0; cyc = 0;
    while (beat <= len && cyc < 200) begin
      exp_d = (burst == INCR) ? model_mem[(word_of(addr) + beat) % NW] : '0;
      check($sformatf("rvalid[%0d]", beat), DW'(rvalid), DW'(1));
      check($sformatf("rdata[%0d]", beat), rdata, exp_d);
      check($sformatf("rresp[%0d]", beat), DW'(rresp), (burst == INCR) ? DW'(0) : DW'(2));
      check($sformatf("rlast[%0d]", beat), DW'(rlast), DW'(beat == len));
      check($sformatf("rid[%0d]", beat), DW'(rid), DW'(id));
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom % 2);
      rready = rr;
      @(negedge clk);
      cyc++;
      if (rr) beat++;
    end
    rready = 1'b0;
    exp_rd_cnt++;
    check("r_beats", DW'(beat), DW'(len + 1));
    check("rvalid_end", DW'(rvalid), DW'(0));
    check("rd_burst_cnt", DW'(rd_burst_cnt), DW'(exp_rd_cnt));
    $display("RD id=%0h addr=%08h len=%0d burst=%0d beats=%0d", id, addr, len, burst, beat);
  endtask

  task automatic fill_full(input int len);
    for (int b = 0; b <= len; b++) begin
      wbeat_data[b] = rand_word();
      wbeat_strb[b] = '1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; arburst = 0; rready = 0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_awready", DW'(awready), DW'(1));
    check("rst_arready", DW'(arready), DW'(1));
    check("rst_wready", DW'(wready), DW'(0));
    check("rst_bvalid", DW'(bvalid), DW'(0));
    check("rst_rvalid", DW'(rvalid), DW'(0));
    check("rst_rlast", DW'(rlast), DW'(0));
    check("rst_resp", DW'({bresp, rresp}), DW'(0));
    check("rst_ids", DW'({bid, rid}), DW'(0));
    check("rst_rdata", rdata, '0);
    check("rst_cnts", DW'({wr_burst_cnt, rd_burst_cnt}), DW'(0));
    check("rst_err_wlast", DW'(err_wlast), DW'(0));
    rst = 1'b0;

    // Basic 4-beat write then read back
    for (int b = 0; b < 4; b++) begin wbeat_data[b] = DW'(b + 1); wbeat_strb[b] = '1; end
    write_burst(9'h011, 32'h40, 3, INCR, -1);
    read_burst(9'h022, 32'h40, 3, INCR, 0);

    // Byte-strobe merge: byte 0 overwritten, the rest keep 0xAA
    wbeat_data[0] = {DB{8'hAA}}; wbeat_strb[0] = '1;
    write_burst(9'h033, 32'h80, 0, INCR, -1);
    wbeat_data[0] = DW'(8'hFF); wbeat_strb[0] = DB'(1);
    write_burst(9'h034, 32'h80, 0, INCR, -1);
    read_burst(9'h035, 32'h80, 0, INCR, 0);

    // 8-beat read with rready toggling every cycle
    fill_full(7);
    write_burst(9'h040, 32'h1000, 7, INCR, -1);
    read_burst(9'h041, 32'h1000, 7, INCR, 1);

    // WLAST early on a 2-beat burst: SLVERR, sticky flag, both beats consumed
    fill_full(1);
    write_burst(9'h050, 32'h200, 1, INCR, 0);
    check("err_wlast_set", DW'(err_wlast), DW'(1));
    read_burst(9'h051, 32'h200, 1, INCR, 0);

    // FIXED read returns zeros/SLVERR while an INCR write runs concurrently
    fill_full(3);
    fork
      read_burst(9'h060, 32'h40, 2, FIXD, 0);
      write_burst(9'h061, 32'h3000, 3, INCR, -1);
    join
    read_burst(9'h062, 32'h3000, 3, INCR, 2);

    // Index wraps at the array end; upper address bits ignored
    fill_full(3);
    write_burst(9'h070, 32'hABCD_0000 | (32'd1022 << 6), 3, INCR, -1);
    read_burst(9'h071, 32'h1234_0000 | (32'd1022 << 6) | 32'h3, 3, INCR, 2);

    // Randomized bursts: full seed write, then partial/odd-burst overwrite, then read
    for (int t = 0; t < 6; t++) begin
      int len;
      int bad;
      logic [AW-1:0] a;
      logic [1:0] wb, rb;
      len = $urandom_range(0, 7);
      a   = $urandom;
      fill_full(len);
      write_burst(IW'($urandom), a, len, INCR, -1);
      for (int b = 0; b <= len; b++) begin
        wbeat_data[b] = rand_word();
        wbeat_strb[b] = {$urandom, $urandom};
      end
      wb  = ($urandom % 4 == 0) ? 2'($urandom_range(2, 3)) : INCR;
      bad = ($urandom % 5 == 0) ? int'($urandom_range(0, len)) : -1;
      write_burst(IW'($urandom), a, len, wb, bad);
      rb  = ($urandom % 4 == 0) ? FIXD : INCR;
      read_burst(IW'($urandom), a, len, rb, 2);
    end
    check("err_wlast_sticky", DW'(err_wlast), DW'(1));

    // Reset during beat 2 of a 4-beat read
    @(negedge clk);
    arvalid = 1'b1; arid = 9'h0AA; araddr = 32'h40; arlen = 8'd3; arburst = INCR;
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    check("mid_rst_beat1_valid", DW'(rvalid), DW'(1));
    rready = 1'b1;
    @(negedge clk);
    check("mid_rst_beat2_data", rdata, model_mem[2]);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_rvalid", DW'(rvalid), DW'(0));
    check("mid_rst_arready", DW'(arready), DW'(1));
    check("mid_rst_rdata", rdata, '0);
    check("mid_rst_cnts", DW'({wr_burst_cnt, rd_burst_cnt}), DW'(0));
    check("mid_rst_err_wlast", DW'(err_wlast), DW'(0));
    rst = 1'b0; rready = 1'b0;
    exp_rd_cnt = 0; exp_wr_cnt = 0;
    $display("RST during read burst id=0aa");
    read_burst(9'h0AB, 32'h40, 3, INCR, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
